// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a start/done handshake,
// status flags and an iterative shift-add multiply.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  operation request, sampled only while busy=0
//   op     operation select (4 bits), latched with start
//   a, b   WIDTH-bit operands, latched with start
//   busy   multiply in progress; start is ignored while high
//   done   one-cycle pulse: res and flags updated this cycle
//   res    WIDTH-bit result, held until the next done
//   zero   res == 0
//   carry  carry / borrow / multiply overflow
//   neg    res[WIDTH-1]
//   ovf    signed two's-complement overflow
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // Single-cycle datapath. Every add/sub op is reduced to x +/- y so one
    // adder and one set of flag equations cover all seven arithmetic codes.
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             is_sub;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;

    logic [2*WIDTH-1:0] mul_sum;

    always_comb begin
        x      = a;
        y      = b;
        is_sub = 1'b0;
        unique case (op)
            4'b1000: begin x = a; y = WIDTH'(1);               end
            4'b1001: begin x = a; y = WIDTH'(1); is_sub = 1'b1; end
            4'b1010: begin x = b; y = WIDTH'(1);               end
            4'b1011: begin x = b; y = WIDTH'(1); is_sub = 1'b1; end
            4'b1100: begin x = a; y = b;                        end
            4'b1101: begin x = b; y = a;         is_sub = 1'b1; end
            4'b1110: begin x = a; y = b;         is_sub = 1'b1; end
            default: begin x = a; y = b;                        end
        endcase

        ext = is_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});

        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        unique case (op)
            4'b0000: alu_r = ~a;
            4'b0001: alu_r = ~b;
            4'b0010: alu_r = a & b;
            4'b0011: alu_r = ~(a & b);
            4'b0100: alu_r = a | b;
            4'b0101: alu_r = ~(a | b);
            4'b0110: alu_r = a ^ b;
            4'b0111: alu_r = ~(a ^ b);
            4'b1111: alu_r = '0;
            default: begin
                alu_r = ext[WIDTH-1:0];
                // ext[WIDTH] is the carry-out for add and the borrow for sub.
                alu_c = ext[WIDTH];
                // Add overflows when signs match, sub when they differ; in
                // both cases the result sign must differ from x.
                alu_v = ((x[WIDTH-1] ^ y[WIDTH-1]) == is_sub) &&
                        (ext[WIDTH-1] != x[WIDTH-1]);
            end
        endcase

        mul_sum = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            res    <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (op == 4'b1111) begin
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= MUL;
                        end else begin
                            res   <= alu_r;
                            zero  <= (alu_r == '0);
                            neg   <= alu_r[WIDTH-1];
                            carry <= alu_c;
                            ovf   <= alu_v;
                            done  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // Final partial product is folded in on the same edge
                    // that publishes the result.
                    if (cnt == CW'(WIDTH - 1)) begin
                        res   <= mul_sum[WIDTH-1:0];
                        zero  <= (mul_sum[WIDTH-1:0] == '0);
                        neg   <= mul_sum[WIDTH-1];
                        carry <= |mul_sum[2*WIDTH-1:WIDTH];
                        ovf   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8). Directed table,
// hand-written handshake sequences and randomized ops checked against an
// integer-arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         neg;
    logic         ovf;

    int vectors     = 0;
    int miscompares = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .zero  (zero),
        .carry (carry),
        .neg   (neg),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic int to_signed(input int u);
        return (u >= 128) ? u - 256 : u;
    endfunction

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
        exp_t e;
        int ua, ub, p, q, r, sr;
        bit sub;
        ua = int'(xa);
        ub = int'(xb);
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        p = 0; q = 0; sub = 0; r = 0;
        case (o)
            4'd0:  r = 255 - ua;
            4'd1:  r = 255 - ub;
            4'd2:  r = ua & ub;
            4'd3:  r = 255 - (ua & ub);
            4'd4:  r = ua | ub;
            4'd5:  r = 255 - (ua | ub);
            4'd6:  r = ua ^ ub;
            4'd7:  r = 255 - (ua ^ ub);
            4'd15: begin
                r = ua * ub;
                e.carry = (r > 255);
            end
            default: begin
                case (o)
                    4'd8:    begin p = ua; q = 1;  sub = 0; end
                    4'd9:    begin p = ua; q = 1;  sub = 1; end
                    4'd10:   begin p = ub; q = 1;  sub = 0; end
                    4'd11:   begin p = ub; q = 1;  sub = 1; end
                    4'd12:   begin p = ua; q = ub; sub = 0; end
                    4'd13:   begin p = ub; q = ua; sub = 1; end
                    default: begin p = ua; q = ub; sub = 1; end
                endcase
                if (sub) begin
                    r  = p - q;
                    e.carry = (r < 0);
                    sr = to_signed(p) - to_signed(q);
                end else begin
                    r  = p + q;
                    e.carry = (r > 255);
                    sr = to_signed(p) + to_signed(q);
                end
                e.ovf = (sr > 127) || (sr < -128);
            end
        endcase
        e.res = W'(r & 255);
        return e;
    endfunction

    // Issue one op and check its completion; returns in the done cycle so
    // the next call's start lands in that same cycle.
    task automatic run_op(input string name, input logic [3:0] o,
                          input logic [W-1:0] xa, input logic [W-1:0] xb, input exp_t e);
        op = o; a = xa; b = xb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // In-flight operation must not depend on inputs after the start cycle.
        op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        if (o == 4'hF) begin
            for (int k = 1; k <= W; k++) begin
                chk({name, " busy/done"}, {busy, done}, 2'b10);
                @(posedge clk); #1;
            end
        end
        chk({name, " done"},  {busy, done}, 2'b01);
        chk({name, " res"},   res,   e.res);
        chk({name, " carry"}, carry, e.carry);
        chk({name, " ovf"},   ovf,   e.ovf);
        chk({name, " neg"},   neg,   e.res[W-1]);
        chk({name, " zero"},  zero,  (e.res == '0));
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, {busy, done, zero, carry, neg, ovf, res}, '0);
    endtask

    initial begin
        vec_t tbl[16];
        int   ndone;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;

        tbl = '{
            '{4'hC, 8'h7F, 8'h01, {8'h80, 1'b0, 1'b1}},
            '{4'hC, 8'hC8, 8'h64, {8'h2C, 1'b1, 1'b0}},
            '{4'hD, 8'h05, 8'h03, {8'hFE, 1'b1, 1'b0}},
            '{4'hF, 8'd13, 8'd11, {8'h8F, 1'b0, 1'b0}},
            '{4'hF, 8'd20, 8'd20, {8'h90, 1'b1, 1'b0}},
            '{4'h0, 8'hA5, 8'h0F, {8'h5A, 1'b0, 1'b0}},
            '{4'h1, 8'hA5, 8'h0F, {8'hF0, 1'b0, 1'b0}},
            '{4'h2, 8'hA5, 8'h0F, {8'h05, 1'b0, 1'b0}},
            '{4'h3, 8'hA5, 8'h0F, {8'hFA, 1'b0, 1'b0}},
            '{4'h4, 8'hA5, 8'h0F, {8'hAF, 1'b0, 1'b0}},
            '{4'h5, 8'hA5, 8'h0F, {8'h50, 1'b0, 1'b0}},
            '{4'h6, 8'hA5, 8'h0F, {8'hAA, 1'b0, 1'b0}},
            '{4'h7, 8'hA5, 8'h0F, {8'h55, 1'b0, 1'b0}},
            '{4'h9, 8'h00, 8'h33, {8'hFF, 1'b1, 1'b0}},
            '{4'h8, 8'hFF, 8'h33, {8'h00, 1'b1, 1'b0}},
            '{4'hE, 8'h80, 8'h01, {8'h7F, 1'b0, 1'b1}}
        };

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset_initial");
        rst = 1'b0;

        // Directed table; consecutive entries exercise back-to-back starts,
        // including a multiply started in the previous multiply's done cycle.
        foreach (tbl[i])
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);

        // Mid-stream reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("reset_midstream");

        // Three back-to-back single-cycle ops, then no further done.
        run_op("b2b0", 4'hC, 8'h10, 8'h20, model(4'hC, 8'h10, 8'h20));
        run_op("b2b1", 4'hE, 8'h10, 8'h20, model(4'hE, 8'h10, 8'h20));
        run_op("b2b2", 4'h6, 8'h3C, 8'hFF, model(4'h6, 8'h3C, 8'hFF));
        @(posedge clk); #1;
        chk("b2b_no_extra_done", done, 1'b0);

        // Start while busy is ignored: exactly one done, multiply result kept.
        op = 4'hF; a = 8'd13; b = 8'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) begin start = 1'b1; op = 4'hC; a = 8'h01; b = 8'h01; end
            if (k == 5) start = 1'b0;
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("busy_ignore_done_count", ndone, 1);
        chk("busy_ignore_res", res, 8'h8F);

        // Reset in cycle T+4 of a multiply aborts it with no done.
        op = 4'hF; a = 8'd20; b = 8'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("mul_abort_state");
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("mul_abort_no_done", ndone, 0);
        chk_reset_state("mul_abort_held");

        // Randomized ops against the reference model.
        for (int i = 0; i < 300; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = W'($urandom);
            run_op($sformatf("rand%0d op%0h a%0h b%0h", i, ro, ra, rb), ro, ra, rb, model(ro, ra, rb));
        end

        @(posedge clk); #1;
        chk("final_idle", {busy, done}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
